// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud counter width and parity helper.
package uart_pkg;

  localparam int BAUD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  // Parity bit a transmitter would send for the low nbits of data (odd=1 selects odd parity).
  function automatic logic parity_bit(input logic [8:0] data, input int nbits, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for a single asynchronous input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d_i;
      sync_reg <= meta_reg;
    end
  end

  assign q_o = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit realigned bit timing, LSB-first data, optional parity, break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [BAUD_W-1:0]    baud_rate_value_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam logic [3:0]        LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [BAUD_W-1:0] CNT_ONE  = BAUD_W'(1);

  logic rx_s;
  logic rx_q_reg;

  uart_rx_state_e       state_reg, state_next;
  logic [BAUD_W-1:0]    cnt_reg, cnt_next;
  logic [BAUD_W-1:0]    n_reg, n_next;
  logic [3:0]           bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_err_reg, par_err_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 perr_out_reg, perr_out_next;
  logic                 ferr_reg, ferr_next;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_q_reg     <= 1'b1;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      n_reg        <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      par_err_reg  <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_out_reg <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      rx_q_reg     <= rx_s;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      n_reg        <= n_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      par_err_reg  <= par_err_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      perr_out_reg <= perr_out_next;
      ferr_reg     <= ferr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = (state_reg == IDLE) ? '0 : cnt_reg + CNT_ONE;
    n_next        = n_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    par_err_next  = par_err_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    perr_out_next = perr_out_reg;
    ferr_next     = ferr_reg;

    case (state_reg)
      IDLE: begin
        if (rx_q_reg && !rx_s) begin
          state_next   = START;
          cnt_next     = '0;
          n_next       = baud_rate_value_i;
          bit_idx_next = '0;
          par_err_next = 1'b0;
        end
      end
      START: begin
        // Half a bit in: a line already back high was only a glitch.
        if (cnt_reg == (n_reg >> 1)) begin
          cnt_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == n_reg) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
          bit_idx_next = bit_idx_reg + 4'd1;
          if (bit_idx_reg == LAST_BIT) state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt_reg == n_reg) begin
          cnt_next     = '0;
          par_err_next = rx_s != parity_bit(9'(shift_reg), DATA_BITS, 1'(PARITY_ODD));
          state_next   = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == n_reg) begin
          cnt_next      = '0;
          data_next     = shift_reg;
          valid_next    = 1'b1;
          perr_out_next = (PARITY_EN != 0) ? par_err_reg : 1'b0;
          ferr_next     = ~rx_s;
          state_next    = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_o       = data_reg;
  assign valid_o      = valid_reg;
  assign parity_err_o = perr_out_reg;
  assign frame_err_o  = ferr_reg;
  assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance and an even-parity instance on separate lines.
module tb_uart_rx;

  localparam int BIT_CLKS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx = 1'b1;
  logic        rx_p = 1'b1;
  logic [15:0] baud = 16'd15;

  logic [7:0] data, data_p;
  logic       valid, perr, ferr, busy;
  logic       valid_p, perr_p, ferr_p, busy_p;

  uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk_i(clk), .rst_i(rst), .baud_rate_value_i(baud), .rx_i(rx),
    .data_o(data), .valid_o(valid), .parity_err_o(perr), .frame_err_o(ferr), .busy_o(busy)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk_i(clk), .rst_i(rst), .baud_rate_value_i(baud), .rx_i(rx_p),
    .data_o(data_p), .valid_o(valid_p), .parity_err_o(perr_p), .frame_err_o(ferr_p), .busy_o(busy_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         c;
  } frame_t;

  frame_t exp_q[$], obs_q[$], exp_pq[$], obs_pq[$];
  int vectors = 0;
  int miscompares = 0;
  int fall_cyc = 0;

  // Monitor records every valid_o pulse; comparisons happen in the test tasks.
  always begin
    frame_t f;
    @(posedge clk);
    #1;
    if (valid === 1'b1) begin
      f.data = data; f.perr = perr; f.ferr = ferr; f.c = cyc;
      obs_q.push_back(f);
    end
    if (valid_p === 1'b1) begin
      f.data = data_p; f.perr = perr_p; f.ferr = ferr_p; f.c = cyc;
      obs_pq.push_back(f);
    end
  end

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par, input logic stopv);
    frame_t e;
    if (!sel) fall_cyc = cyc;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (sel) drive_bit(sel, par);
    e.data = d;
    e.perr = sel ? ((^d ^ par) != 1'b0) : 1'b0;
    e.ferr = ~stopv;
    e.c    = 0;
    if (sel) exp_pq.push_back(e);
    else     exp_q.push_back(e);
    drive_bit(sel, stopv);
  endtask

  task automatic wait_obs(input bit sel, input int n);
    for (int i = 0; i < 400; i++) begin
      if ((sel ? obs_pq.size() : obs_q.size()) >= n) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_pair(input bit sel, output frame_t o, output frame_t e, output bit ok);
    o = '{default: 0};
    e = '{default: 0};
    ok = sel ? (obs_pq.size() > 0 && exp_pq.size() > 0) : (obs_q.size() > 0 && exp_q.size() > 0);
    if (ok) begin
      if (sel) begin o = obs_pq.pop_front(); e = exp_pq.pop_front(); end
      else     begin o = obs_q.pop_front();  e = exp_q.pop_front();  end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({data, valid, perr, ferr, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_8n1: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0", data, valid, perr, ferr, busy);
    end
    vectors++;
    if ({data_p, valid_p, perr_p, ferr_p, busy_p} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_par: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0", data_p, valid_p, perr_p, ferr_p, busy_p);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    frame_t o, e;
    bit ok;
    int lat;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    wait_obs(1'b0, 1);
    pop_pair(1'b0, o, e, ok);
    vectors++;
    if (!ok || {o.data, o.perr, o.ferr} !== {e.data, e.perr, e.ferr}) begin
      miscompares++;
      $display("FAIL basic_a5: got ok=%b data=%h pe=%b fe=%b, want data=%h pe=%b fe=%b", ok, o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
    end
    lat = o.c - fall_cyc;
    vectors++;
    if (!ok || lat < 149 || lat > 155) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d clocks, want 149..155", lat);
    end
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (obs_q.size() != 0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_single_pulse: got %0d extra frames valid=%b, want 0 and 0", obs_q.size(), valid);
    end
  endtask

  task automatic test_back_to_back();
    frame_t o, e;
    bit ok;
    send_frame(1'b0, 8'h00, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1);
    wait_obs(1'b0, 2);
    for (int k = 0; k < 2; k++) begin
      pop_pair(1'b0, o, e, ok);
      vectors++;
      if (!ok || {o.data, o.perr, o.ferr} !== {e.data, e.perr, e.ferr}) begin
        miscompares++;
        $display("FAIL b2b_frame%0d: got ok=%b data=%h pe=%b fe=%b, want data=%h pe=%b fe=%b", k, ok, o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
      end
    end
  endtask

  task automatic test_parity();
    frame_t o, e;
    bit ok;
    send_frame(1'b1, 8'h03, 1'b1, 1'b1);
    wait_obs(1'b1, 1);
    pop_pair(1'b1, o, e, ok);
    vectors++;
    if (!ok || {o.data, o.perr, o.ferr} !== {e.data, e.perr, e.ferr}) begin
      miscompares++;
      $display("FAIL parity_bad: got ok=%b data=%h pe=%b fe=%b, want data=%h pe=%b fe=%b", ok, o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
    end
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (perr_p !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_held: got %b, want 1", perr_p);
    end
    send_frame(1'b1, 8'h03, 1'b0, 1'b1);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1);
    wait_obs(1'b1, 2);
    for (int k = 0; k < 2; k++) begin
      pop_pair(1'b1, o, e, ok);
      vectors++;
      if (!ok || {o.data, o.perr, o.ferr} !== {e.data, e.perr, e.ferr}) begin
        miscompares++;
        $display("FAIL parity_good%0d: got ok=%b data=%h pe=%b fe=%b, want data=%h pe=%b fe=%b", k, ok, o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
      end
    end
  endtask

  task automatic test_break();
    frame_t o, e;
    bit ok;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) drive_bit(1'b0, 1'b0);
    vectors++;
    if (obs_q.size() != 1 || busy !== 1'b1 || ferr !== 1'b1) begin
      miscompares++;
      $display("FAIL break_hold: got frames=%0d busy=%b fe=%b, want 1 1 1", obs_q.size(), busy, ferr);
    end
    pop_pair(1'b0, o, e, ok);
    vectors++;
    if (!ok || {o.data, o.perr, o.ferr} !== {e.data, e.perr, e.ferr}) begin
      miscompares++;
      $display("FAIL break_frame: got ok=%b data=%h pe=%b fe=%b, want data=%h pe=%b fe=%b", ok, o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
    end
    drive_bit(1'b0, 1'b1);
    vectors++;
    if (busy !== 1'b0 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL break_release: got busy=%b frames=%0d, want 0 0", busy, obs_q.size());
    end
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
    wait_obs(1'b0, 1);
    pop_pair(1'b0, o, e, ok);
    vectors++;
    if (!ok || {o.data, o.perr, o.ferr} !== {e.data, e.perr, e.ferr}) begin
      miscompares++;
      $display("FAIL break_next: got ok=%b data=%h pe=%b fe=%b, want data=%h pe=%b fe=%b", ok, o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
    end
  endtask

  task automatic test_glitch();
    int bc = 0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) bc++;
    end
    vectors++;
    if (bc < 1 || bc >= 12 || busy !== 1'b0 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL glitch: got busy_cycles=%0d busy=%b frames=%0d, want 1..11 0 0", bc, busy, obs_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    frame_t o, e;
    bit ok;
    logic [7:0] d;
    d = 8'h5A;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i]);
    rx = d[4];
    repeat (8) @(posedge clk);
    vectors++;
    if (busy !== 1'b1 || data !== 8'h3C) begin
      miscompares++;
      $display("FAIL pre_reset: got busy=%b data=%h, want 1 3c", busy, data);
    end
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({data, valid, perr, ferr, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_midframe: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0", data, valid, perr, ferr, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx = 1'b1;
    for (int k = 0; k < 3; k++) drive_bit(1'b0, 1'b1);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    wait_obs(1'b0, 1);
    pop_pair(1'b0, o, e, ok);
    vectors++;
    if (!ok || {o.data, o.perr, o.ferr} !== {e.data, e.perr, e.ferr}) begin
      miscompares++;
      $display("FAIL after_reset_81: got ok=%b data=%h pe=%b fe=%b, want data=%h pe=%b fe=%b", ok, o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
    end
  endtask

  task automatic test_baud_change();
    frame_t o, e;
    bit ok;
    fork
      send_frame(1'b0, 8'h96, 1'b0, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #1;
        baud = 16'd7;
      end
    join
    wait_obs(1'b0, 1);
    pop_pair(1'b0, o, e, ok);
    vectors++;
    if (!ok || {o.data, o.perr, o.ferr} !== {e.data, e.perr, e.ferr}) begin
      miscompares++;
      $display("FAIL baud_change_96: got ok=%b data=%h pe=%b fe=%b, want data=%h pe=%b fe=%b", ok, o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
    end
    baud = 16'd15;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_break();
    test_glitch();
    test_reset_midframe();
    test_baud_change();
    vectors++;
    if (obs_q.size() != 0 || obs_pq.size() != 0) begin
      miscompares++;
      $display("FAIL stray_frames: got %0d/%0d unexpected frames, want 0/0", obs_q.size(), obs_pq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the link side of the UART/CRC datapath. It deserialises an asynchronous 8N1-style frame on rx_i into a parallel word and flags parity and framing errors. It uses the same 16-bit baud_rate_value_i programming as the baud generator: one bit period is baud_rate_value_i+1 clocks. It runs its own bit-timing counter, realigned to each start bit, so it does not depend on the free-running generator phase. Its output feeds the CRC checker and the RX buffer.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9), LSB first.
PARITY_EN, 0, 1 = one parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  asynchronous reset, active-high.
baud_rate_value_i  input  16  bit period minus one, in clk_i cycles (N); legal range 3..65535.
rx_i  input  1  asynchronous serial line; idle high.
data_o  output  DATA_BITS  last received word; holds until the next frame completes.
valid_o  output  1  one-cycle pulse when a frame completes; data_o and error flags are valid with it.
parity_err_o  output  1  parity mismatch for the frame reported by valid_o; held until the next valid_o.
frame_err_o  output  1  stop bit sampled low for the frame reported by valid_o; held until the next valid_o.
busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset and clocking: reset is rst_i (asynchronous, active-high) and the clock is clk_i.
- Reset values: data_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0. Synchroniser flops reset to 1, state=IDLE, counter=0, bit index=0.
- rx_i passes through a 2-flop synchroniser (rx_s). All decisions use rx_s. A further flop rx_q detects the falling edge (rx_q=1, rx_s=0).
- N is latched from baud_rate_value_i on IDLE->START. Changes to baud_rate_value_i mid-frame have no effect until the next frame.
- Counter is 16-bit. It increments each clock in non-IDLE states and clears to 0 on every sample event.
- IDLE: falling edge on rx_s -> START, counter=0.
- START: when counter==(N>>1):
  - rx_s==0 -> DATA, counter=0. The sample point is now mid-bit.
  - rx_s==1 -> glitch; return to IDLE with no valid_o.
- DATA: when counter==N, sample rx_s into the shift register. The new bit enters at the MSB and the register shifts right, so the first bit ends up at the LSB. Bit index increments and counter=0.
  - After DATA_BITS samples: go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: when counter==N, sample the parity bit.
  - Even parity: error = XOR(data bits, parity bit) != 0.
  - Odd parity: error = XOR(data bits, parity bit) != 1.
  - Go to STOP, counter=0.
- STOP: when counter==N, sample the stop bit. On that same edge:
  - data_o <= shift register, valid_o <= 1, parity_err_o <= the parity error (0 if PARITY_EN=0), frame_err_o <= ~rx_s.
  - If rx_s==1 -> IDLE; if rx_s==0 -> BREAK.
- Output latency: valid_o is high for exactly the one cycle following the stop-sample edge.
- BREAK: wait until rx_s==1, then -> IDLE. This prevents a held-low line from being read as repeated frames. No valid_o is produced while in BREAK.
- Back-to-back frames: the STOP->IDLE transition happens mid stop bit, so a start edge arriving at the next bit boundary is caught. There are no dead cycles beyond the synchroniser delay.
- Reset mid-frame: returns immediately to IDLE, clears all outputs and discards the partial frame.
- N outside the legal range (<3) is unsupported and is not verified.

Decomposition:
- uart_pkg holds:
  - the state enum uart_rx_state_e {IDLE, START, DATA, PARITY, STOP, BREAK};
  - the constant BAUD_W=16;
  - the parity helper function, shared with the future uart_tx.
- One sub-module: uart_sync2, a generic 2-flop synchroniser with a reset value parameter (RST_VAL=1). It is reused for any async input.

Test Plan:
1. N=15, 8N1, send 0xA5 -> exactly one valid_o pulse, data_o=0xA5, both errors 0. valid_o occurs 9.5*16 +/-3 clocks after the rx_i falling edge.
2. N=15, send 0x00 then 0xFF back-to-back with a single stop bit each -> two valid_o pulses, data_o=0x00 then 0xFF, no errors.
3. PARITY_EN=1 with PARITY_ODD=0, send 0x03 with parity bit 1 -> parity_err_o=1 at valid_o. Resend with parity bit 0 -> parity_err_o=0.
4. N=15, send 0x55 with the stop bit driven 0 and the line held low for 40 bit periods -> one valid_o with frame_err_o=1, then no further valid_o until the line returns high. A following 0x3C is received correctly.
5. N=15, 4-clock low glitch on rx_i -> FSM returns to IDLE, no valid_o, busy_o high for fewer than 12 cycles.
6. N=15, assert rst_i during DATA bit 4 -> all outputs 0 and busy_o=0 immediately. The next full frame 0x81 is received correctly. Also change baud_rate_value_i mid-frame -> the current frame still decodes at N=15.
